clint_mh: RTL and testbench

- Multi-hart core-local interruptor: one shared 64-bit mtime, plus a per-hart msip bit and a per-hart 64-bit mtimecmp.
- mtime advances on a programmable prescaler tick.
- Memory-mapped slave on the core data bus; accepts byte, half and word accesses.
- Registered read data; registered per-hart software and timer interrupt outputs feeding each hart's mip.

---
 rtl/clint_pkg.sv | 38 +++
 rtl/clint_timebase.sv | 35 +++
 rtl/clint_mh.sv | 119 +++++++++++
 tb/tb_clint_mh.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/clint_pkg.sv
// Shared constants, access-size encoding and byte-lane helpers for the CLINT.
package clint_pkg;

    localparam logic [15:0] MSIP_OFS     = 16'h0000;
    localparam logic [15:0] MTIMECMP_OFS = 16'h4000;
    localparam logic [15:0] MTIME_OFS    = 16'hBFF8;

    typedef enum logic [1:0] {
        SZ_B    = 2'd0,
        SZ_H    = 2'd1,
        SZ_W    = 2'd2,
        SZ_RSVD = 2'd3
    } size_e;

    // Byte enables for an access of the given size at the given lane.
    function automatic logic [3:0] lane_mask(input size_e size, input logic [1:0] lo);
        logic [3:0] mask;
        case (size)
            SZ_B:    mask = 4'b0001 << lo;
            SZ_H:    mask = lo[1] ? 4'b1100 : 4'b0011;
            SZ_W:    mask = 4'b1111;
            default: mask = 4'b0000;
        endcase
        return mask;
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  mask);
        logic [31:0] res;
        res = old_w;
        for (int b = 0; b < 4; b++) begin
            if (mask[b]) res[8*b +: 8] = wdata[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/clint_timebase.sv
// Prescaler plus 64-bit mtime counter; a half-load freezes the other half for that cycle.
module clint_timebase #(
    parameter int TICK_DIV = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_ld_lo,
    input  logic        i_ld_hi,
    input  logic [31:0] i_ld_data,
    output logic [63:0] o_mtime
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PW-1:0] r_pre;
    logic [63:0]   r_mtime;
    logic          w_tick;

    assign w_tick  = (r_pre == PW'(TICK_DIV - 1));
    assign o_mtime = r_mtime;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre   <= '0;
            r_mtime <= '0;
        end else begin
            r_pre <= w_tick ? '0 : r_pre + PW'(1);
            // A software load wins over the tick; the tick (and its carry) is dropped.
            if (i_ld_lo)       r_mtime[31:0]  <= i_ld_data;
            else if (i_ld_hi)  r_mtime[63:32] <= i_ld_data;
            else if (w_tick)   r_mtime        <= r_mtime + 64'd1;
        end
    end

endmodule

// File: rtl/clint_mh.sv
// Multi-hart CLINT: shared mtime, per-hart msip and mtimecmp, registered bus responses.
module clint_mh
    import clint_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
    parameter int          NUM_HARTS = 1,
    parameter int          TICK_DIV  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 read,
    input  logic                 write,
    input  logic [31:0]          addr,
    input  logic [1:0]           size,
    input  logic [31:0]          write_data,
    output logic [31:0]          read_data,
    output logic                 read_valid,
    output logic                 access_err,
    output logic [NUM_HARTS-1:0] software_int,
    output logic [NUM_HARTS-1:0] timer_int
);
    localparam int HW = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1;

    size_e          w_size;
    logic [13:0]    w_word, w_msip_word, w_cmp_word;
    logic [HW-1:0]  w_msip_idx, w_cmp_idx;
    logic           w_in_win, w_misalign, w_bad, w_wr_ok;
    logic           w_msip_hit, w_cmp_hit, w_mtlo_hit, w_mthi_hit;
    logic [3:0]     w_mask;
    logic [31:0]    w_rword, w_ld_data;
    logic [63:0]    w_mtime;

    logic [NUM_HARTS-1:0] r_msip, r_timer;
    logic [63:0]          r_mtimecmp [NUM_HARTS];
    logic [31:0]          r_read_data;
    logic                 r_read_valid, r_access_err;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_size      = size_e'(size);
        w_word      = addr[15:2];
        w_in_win    = (addr[31:16] == BASE_ADDR[31:16]);
        w_msip_word = w_word - 14'(MSIP_OFS >> 2);
        w_cmp_word  = w_word - 14'(MTIMECMP_OFS >> 2);
        w_msip_idx  = w_msip_word[HW-1:0];
        w_cmp_idx   = w_cmp_word[HW:1];

        w_msip_hit = w_in_win && (w_word < 14'(MTIMECMP_OFS >> 2))
                     && (w_msip_word < 14'(NUM_HARTS));
        w_cmp_hit  = w_in_win && (w_word >= 14'(MTIMECMP_OFS >> 2))
                     && (w_cmp_word[13:1] < 13'(NUM_HARTS));
        w_mtlo_hit = w_in_win && (w_word == 14'(MTIME_OFS >> 2));
        w_mthi_hit = w_in_win && (w_word == 14'((MTIME_OFS + 16'd4) >> 2));

        w_misalign = (w_size == SZ_RSVD)
                     || (w_size == SZ_H && addr[0])
                     || (w_size == SZ_W && addr[1:0] != 2'b00);
        w_bad      = w_misalign || !(w_msip_hit || w_cmp_hit || w_mtlo_hit || w_mthi_hit);
        w_wr_ok    = write && !w_bad;
        w_mask     = lane_mask(w_size, addr[1:0]);

        w_rword = '0;
        for (int h = 0; h < NUM_HARTS; h++) begin
            if (w_msip_hit && w_msip_idx == HW'(h)) w_rword = {31'b0, r_msip[h]};
            if (w_cmp_hit && w_cmp_idx == HW'(h))
                w_rword = w_cmp_word[0] ? r_mtimecmp[h][63:32] : r_mtimecmp[h][31:0];
        end
        if (w_mtlo_hit) w_rword = w_mtime[31:0];
        if (w_mthi_hit) w_rword = w_mtime[63:32];

        w_ld_data = merge_bytes(w_mthi_hit ? w_mtime[63:32] : w_mtime[31:0], write_data, w_mask);
    end

    clint_timebase #(
        .TICK_DIV (TICK_DIV)
    ) u_timebase (
        .clk       (clk),
        .rst       (rst),
        .i_ld_lo   (w_wr_ok && w_mtlo_hit),
        .i_ld_hi   (w_wr_ok && w_mthi_hit),
        .i_ld_data (w_ld_data),
        .o_mtime   (w_mtime)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_msip       <= '0;
            r_timer      <= '0;
            r_read_data  <= '0;
            r_read_valid <= 1'b0;
            r_access_err <= 1'b0;
            // NOTE: the compare array is a handful of flops with a defined reset value, not a RAM.
            for (int h = 0; h < NUM_HARTS; h++) r_mtimecmp[h] <= '1;
        end else begin
            r_read_valid <= read && !write;
            r_access_err <= (read && write) || ((read || write) && w_bad);
            if (read && !write) r_read_data <= w_bad ? '0 : w_rword;

            for (int h = 0; h < NUM_HARTS; h++) begin
                r_timer[h] <= (w_mtime >= r_mtimecmp[h]);
                if (w_wr_ok && w_msip_hit && w_msip_idx == HW'(h) && w_mask[0])
                    r_msip[h] <= write_data[0];
                if (w_wr_ok && w_cmp_hit && w_cmp_idx == HW'(h)) begin
                    if (w_cmp_word[0])
                        r_mtimecmp[h][63:32] <= merge_bytes(r_mtimecmp[h][63:32], write_data, w_mask);
                    else
                        r_mtimecmp[h][31:0]  <= merge_bytes(r_mtimecmp[h][31:0], write_data, w_mask);
                end
            end
        end
    end

    assign read_data    = r_read_data;
    assign read_valid   = r_read_valid;
    assign access_err   = r_access_err;
    assign software_int = r_msip;
    assign timer_int    = r_timer;

endmodule

// File: tb/tb_clint_mh.sv
// Two CLINTs (TICK_DIV 1 and 4) on a shared bus, checked every cycle against a behavioural model.
module tb_clint_mh;
    localparam logic [31:0] BASE = 32'h0200_0000;
    localparam int NH = 2;
    localparam int K_NONE = 0, K_MSIP = 1, K_CMPLO = 2, K_CMPHI = 3, K_MTLO = 4, K_MTHI = 5;

    logic        clk = 1'b0, rst = 1'b1, read = 1'b0, write = 1'b0;
    logic [31:0] addr = '0, write_data = '0;
    logic [1:0]  size = '0;

    logic [31:0]   rd0, rd1;
    logic          rv0, rv1, ae0, ae1;
    logic [NH-1:0] si0, si1, ti0, ti1;

    clint_mh #(.BASE_ADDR(BASE), .NUM_HARTS(NH), .TICK_DIV(1)) dut (
        .clk(clk), .rst(rst), .read(read), .write(write), .addr(addr), .size(size),
        .write_data(write_data), .read_data(rd0), .read_valid(rv0), .access_err(ae0),
        .software_int(si0), .timer_int(ti0));

    clint_mh #(.BASE_ADDR(BASE), .NUM_HARTS(NH), .TICK_DIV(4)) dut4 (
        .clk(clk), .rst(rst), .read(read), .write(write), .addr(addr), .size(size),
        .write_data(write_data), .read_data(rd1), .read_valid(rv1), .access_err(ae1),
        .software_int(si1), .timer_int(ti1));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: index d selects the TICK_DIV=1 (d=0) or TICK_DIV=4 (d=1) instance.
    logic [63:0]   m_mtime [2];
    logic [63:0]   m_cmp   [NH];
    logic [NH-1:0] m_msip;
    int unsigned   m_edges;
    logic [31:0]   m_rdata [2];
    logic          m_rvalid, m_err;
    logic [NH-1:0] m_tint  [2];

    function automatic int div_of(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void decode(input logic [31:0] a, input logic [1:0] sz,
                                   output int kind, output int idx, output bit bad);
        longint off;
        int     w;
        kind = K_NONE;
        idx  = 0;
        bad  = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
        off  = longint'({32'h0, a}) - longint'({32'h0, BASE});
        if (off >= 0 && off < 65536) begin
            w = (int'(off) / 4) * 4;
            if (w < 4 * NH) begin
                kind = K_MSIP; idx = w / 4;
            end else if (w >= 'h4000 && w < 'h4000 + 8 * NH) begin
                idx  = (w - 'h4000) / 8;
                kind = ((w - 'h4000) % 8 == 0) ? K_CMPLO : K_CMPHI;
            end else if (w == 'hBFF8) begin
                kind = K_MTLO;
            end else if (w == 'hBFFC) begin
                kind = K_MTHI;
            end
        end
        if (kind == K_NONE) bad = 1'b1;
    endfunction

    function automatic logic [31:0] pre_word(input int kind, input int idx, input int d);
        case (kind)
            K_MSIP:  return {31'b0, m_msip[idx]};
            K_CMPLO: return m_cmp[idx][31:0];
            K_CMPHI: return m_cmp[idx][63:32];
            K_MTLO:  return m_mtime[d][31:0];
            K_MTHI:  return m_mtime[d][63:32];
            default: return 32'h0;
        endcase
    endfunction

    // Replace the bytes covered by the access, walking byte addresses.
    function automatic logic [31:0] apply_bytes(input logic [31:0] old_w, input logic [31:0] wd,
                                                input logic [31:0] a, input logic [1:0] sz);
        logic [31:0] r;
        int lane;
        r = old_w;
        for (int k = 0; k < (1 << sz); k++) begin
            lane = int'((a + 32'(k)) % 32'd4);
            r[lane*8 +: 8] = wd[lane*8 +: 8];
        end
        return r;
    endfunction

    task automatic model_edge();
        int kind, idx;
        bit bad, wr_ok;
        logic [31:0] rw [2];
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                m_mtime[d] = '0; m_rdata[d] = '0; m_tint[d] = '0;
            end
            for (int h = 0; h < NH; h++) m_cmp[h] = '1;
            m_msip = '0; m_edges = 0; m_rvalid = 1'b0; m_err = 1'b0;
            return;
        end
        m_edges++;
        for (int d = 0; d < 2; d++)
            for (int h = 0; h < NH; h++) m_tint[d][h] = (m_mtime[d] >= m_cmp[h]);
        decode(addr, size, kind, idx, bad);
        wr_ok = write && !bad;
        for (int d = 0; d < 2; d++) begin
            rw[d] = pre_word(kind, idx, d);
            if (wr_ok && kind == K_MTLO)      m_mtime[d][31:0]  = apply_bytes(rw[d], write_data, addr, size);
            else if (wr_ok && kind == K_MTHI) m_mtime[d][63:32] = apply_bytes(rw[d], write_data, addr, size);
            else if (m_edges % div_of(d) == 0) m_mtime[d] = m_mtime[d] + 64'd1;
        end
        if (wr_ok && kind == K_MSIP && addr[1:0] == 2'b00) m_msip[idx] = write_data[0];
        if (wr_ok && kind == K_CMPLO) m_cmp[idx][31:0]  = apply_bytes(rw[0], write_data, addr, size);
        if (wr_ok && kind == K_CMPHI) m_cmp[idx][63:32] = apply_bytes(rw[0], write_data, addr, size);
        if (read && write) begin
            m_rvalid = 1'b0; m_err = 1'b1;
        end else if (read) begin
            m_rvalid = 1'b1; m_err = bad;
            for (int d = 0; d < 2; d++) m_rdata[d] = bad ? 32'h0 : rw[d];
        end else begin
            m_rvalid = 1'b0; m_err = write && bad;
        end
    endtask

    task automatic tick_and_check();
        @(posedge clk);
        model_edge();
        #1;
        check("read_data0", 64'(rd0), 64'(m_rdata[0]));
        check("read_data1", 64'(rd1), 64'(m_rdata[1]));
        check("read_valid0", 64'(rv0), 64'(m_rvalid));
        check("read_valid1", 64'(rv1), 64'(m_rvalid));
        check("access_err0", 64'(ae0), 64'(m_err));
        check("access_err1", 64'(ae1), 64'(m_err));
        check("software_int0", 64'(si0), 64'(m_msip));
        check("software_int1", 64'(si1), 64'(m_msip));
        check("timer_int0", 64'(ti0), 64'(m_tint[0]));
        check("timer_int1", 64'(ti1), 64'(m_tint[1]));
    endtask

    task automatic access(input bit rd, input bit wr, input logic [31:0] a,
                          input logic [1:0] sz, input logic [31:0] wd);
        read = rd; write = wr; addr = a; size = sz; write_data = wd;
        tick_and_check();
        read = 1'b0; write = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick_and_check();
    endtask

    logic [31:0] v1, v2;
    logic [31:0] offs [13] = '{32'h0, 32'h4, 32'h8, 32'h4000, 32'h4004, 32'h4008, 32'h400C,
                               32'h4010, 32'h4014, 32'hBFF8, 32'hBFFC, 32'h1234, 32'hBFF0};

    initial begin
        // Reset
        idle(3);
        check("reset_timer_int", 64'(ti0), 64'd0);
        check("reset_software_int", 64'(si0), 64'd0);
        check("reset_read_valid", 64'(rv0), 64'd0);
        rst = 1'b0;
        idle(2);

        // mtime advances once per cycle with TICK_DIV=1
        access(1, 0, BASE + 32'hBFF8, 2'd2, 32'h0);
        v1 = rd0;
        idle(2);
        access(1, 0, BASE + 32'hBFF8, 2'd2, 32'h0);
        v2 = rd0;
        check("mtime_delta3", 64'(v2 - v1), 64'd3);

        // timer_int[1] rises the cycle after mtime reaches mtimecmp[1]=10
        access(0, 1, BASE + 32'h4008, 2'd2, 32'd10);
        access(0, 1, BASE + 32'h400C, 2'd2, 32'd0);
        access(0, 1, BASE + 32'hBFFC, 2'd2, 32'd0);
        access(0, 1, BASE + 32'hBFF8, 2'd2, 32'd0);
        for (int i = 1; i <= 12; i++) begin
            tick_and_check();
            check("timer1_rise", 64'(ti0[1]), 64'(i >= 11));
            check("timer0_quiet", 64'(ti0[0]), 64'd0);
        end

        // msip via byte then half write
        access(0, 1, BASE + 32'h4, 2'd0, 32'h0000_0001);
        check("msip_set", 64'(si0), 64'b10);
        access(0, 1, BASE + 32'h4, 2'd1, 32'h0000_0000);
        check("msip_clear", 64'(si0), 64'b00);

        // 32-bit carry into mtime hi
        access(0, 1, BASE + 32'hBFFC, 2'd2, 32'h0);
        access(0, 1, BASE + 32'hBFF8, 2'd2, 32'hFFFF_FFFF);
        idle(1);
        access(1, 0, BASE + 32'hBFFC, 2'd2, 32'h0);
        check("mtime_hi_carry", 64'(rd0), 64'd1);

        // TICK_DIV=4: 10 increments over 40 clocks
        access(0, 1, BASE + 32'hBFF8, 2'd2, 32'h0);
        access(1, 0, BASE + 32'hBFF8, 2'd2, 32'h0);
        v1 = rd1;
        idle(39);
        access(1, 0, BASE + 32'hBFF8, 2'd2, 32'h0);
        v2 = rd1;
        check("div4_delta40", 64'(v2 - v1), 64'd10);

        // Error cases
        access(0, 1, BASE + 32'h4002, 2'd2, 32'hDEAD_BEEF);
        check("misaligned_err", 64'(ae0), 64'd1);
        access(1, 0, BASE + 32'h4000, 2'd2, 32'h0);
        check("cmp0_untouched", 64'(rd0), 64'hFFFF_FFFF);
        access(1, 0, BASE + 32'h0010, 2'd2, 32'h0);
        check("unmapped_err", 64'(ae0), 64'd1);
        check("unmapped_valid", 64'(rv0), 64'd1);
        check("unmapped_data", 64'(rd0), 64'd0);
        access(1, 1, BASE + 32'h0, 2'd2, 32'h1);
        check("rw_err", 64'(ae0), 64'd1);
        check("rw_valid", 64'(rv0), 64'd0);
        check("rw_write_done", 64'(si0), 64'b01);
        access(1, 0, BASE + 32'h0, 2'd3, 32'h0);
        check("rsvd_size_err", 64'(ae0), 64'd1);

        // Randomized traffic with occasional mid-run reset
        for (int n = 0; n < 800; n++) begin
            int sel;
            logic [31:0] a, wd;
            logic [1:0] sz;
            sel = int'($urandom_range(99));
            a   = BASE + offs[$urandom_range(12)];
            if ($urandom_range(9) < 2) a = a + 32'($urandom_range(3));
            if ($urandom_range(29) == 0) a = 32'h0300_0000 + (a & 32'hFFFC);
            sz  = ($urandom_range(3) == 0) ? 2'($urandom_range(3)) : 2'd2;
            wd  = $urandom_range(1) ? 32'($urandom_range(64)) : $urandom;
            rst = ($urandom_range(149) == 0);
            access(sel < 40, sel >= 35 && sel < 75, a, sz, wd);
            rst = 1'b0;
        end

        // Reset clears a read issued in the same cycle
        rst = 1'b1;
        access(1, 0, BASE + 32'hBFF8, 2'd2, 32'h0);
        check("reset_kills_valid", 64'(rv0), 64'd0);
        check("reset_kills_data", 64'(rd0), 64'd0);
        rst = 1'b0;
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
